// File: rtl/nibble_tx_if.sv
// Nibble transmitter bus: write strobe/data toward the transmitter, serial line and FIFO status back.
// Latency: wires only, no state.
// Backpressure: none in the bus; the producer watches full/overflow and may drop writes.
interface nibble_tx_if;
   logic       wr_en;
   logic [3:0] data_in;
   logic       tx;
   logic       busy;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;

   // Producer side (processor OUT port / testbench).
   modport master (
      output wr_en,
      output data_in,
      input  tx,
      input  busy,
      input  empty,
      input  full,
      input  count,
      input  overflow
   );

   // Transmitter side.
   modport slave (
      input  wr_en,
      input  data_in,
      output tx,
      output busy,
      output empty,
      output full,
      output count,
      output overflow
   );
endinterface

// File: rtl/nibble_tx.sv
// Nibble UART-style transmitter fed by a DEPTH x 4 FIFO; frame = start, 4 data bits LSB first, [parity], stop.
// Latency: a write lands at its edge; an idle line pops it one edge later and tx drops that same edge.
// Backpressure: writes while full are dropped (sticky overflow) unless the FSM pops on the same edge.
// Optional even-parity bit: define NIBBLE_TX_PARITY_EN.
module nibble_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH        = 8
) (
   input  logic       clock,
   input  logic       reset,
   nibble_tx_if.slave bus
);

   localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0]      BIT_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [4:0]      DEPTH_C  = 5'(DEPTH);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef NIBBLE_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   // FIFO storage and bookkeeping
   logic [3:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [4:0]    r_count;
   logic          r_overflow;

   // Serializer state
   logic [2:0]    r_state;
   logic          r_tx;
   logic          r_busy;
   logic [7:0]    r_bit_cnt;
   logic [1:0]    r_idx;
   logic [3:0]    r_shift;

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_bit_done;

   // Status comes straight from the registered occupancy count.
   assign w_empty    = (r_count == 5'd0);
   assign w_full     = (r_count == DEPTH_C);

   // The only consumer is the FSM, and it only pops from IDLE.
   assign w_pop      = (r_state == S_IDLE) && !w_empty;

   // A pop on the same edge frees the slot, so a write to a full FIFO still lands.
   assign w_push     = bus.wr_en && (!w_full || w_pop);

   assign w_bit_done = (r_bit_cnt == 8'd0);

   assign bus.tx       = r_tx;
   assign bus.busy     = r_busy;
   assign bus.empty    = w_empty;
   assign bus.full     = w_full;
   assign bus.count    = r_count;
   assign bus.overflow = r_overflow;

   // FIFO data array; contents are don't-care until written, so no reset here.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.data_in;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= 5'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 5'd1;
            2'b01:   r_count <= r_count - 5'd1;
            default: r_count <= r_count;
         endcase
         if (bus.wr_en && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Frame FSM: every state holds tx for CLKS_PER_BIT cycles using a down-counter reloaded on each bit change.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_bit_cnt <= 8'd0;
         r_idx     <= 2'd0;
         r_shift   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (w_pop) begin
                  r_state   <= S_START;
                  r_tx      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= BIT_LAST;
                  r_shift   <= r_mem[r_rd_ptr];
               end
            end

            S_START: begin
               if (w_bit_done) begin
                  r_state   <= S_DATA;
                  r_tx      <= r_shift[0];
                  r_idx     <= 2'd0;
                  r_bit_cnt <= BIT_LAST;
               end else begin
                  r_bit_cnt <= r_bit_cnt - 8'd1;
               end
            end

            S_DATA: begin
               if (w_bit_done) begin
                  r_bit_cnt <= BIT_LAST;
                  if (r_idx == 2'd3) begin
`ifdef NIBBLE_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= ^r_shift;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_idx <= r_idx + 2'd1;
                     r_tx  <= r_shift[r_idx + 2'd1];
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt - 8'd1;
               end
            end

`ifdef NIBBLE_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_done) begin
                  r_state   <= S_STOP;
                  r_tx      <= 1'b1;
                  r_bit_cnt <= BIT_LAST;
               end else begin
                  r_bit_cnt <= r_bit_cnt - 8'd1;
               end
            end
`endif

            S_STOP: begin
               // Always return through IDLE, even with data waiting: that IDLE cycle is the inter-frame gap.
               if (w_bit_done) begin
                  r_state <= S_IDLE;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_bit_cnt <= r_bit_cnt - 8'd1;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_tx      <= 1'b1;
               r_busy    <= 1'b0;
               r_bit_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_tx.sv
// Testbench for nibble_tx: directed scenarios with random nibble values.
// A line monitor rebuilds each frame from tx and compares it with the ideal waveform of the next expected nibble.
// Expected nibbles are queued in write order, so transmit order is checked too.
module tb_nibble_tx;

   localparam int C = 4;
   localparam int D = 8;
`ifdef NIBBLE_TX_PARITY_EN
   localparam int NSLOT = 7;
`else
   localparam int NSLOT = 6;
`endif
   localparam int FL = NSLOT * C;

   typedef struct {
      int mism;
      int busy_n;
      int gap;
   } res_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [3:0] exp_q [$];
   res_t       res_q [$];

   nibble_tx_if bus ();

   nibble_tx #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Ideal line level in bit slot s of a frame carrying nibble n.
   function automatic logic slot_bit(input logic [3:0] n, input int s);
      if (s == 0)         return 1'b0;
      if (s <= 4)         return n[s-1];
      if (s == NSLOT - 1) return 1'b1;
      return ^n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic put(input logic [3:0] d);
      bus.wr_en   = 1'b1;
      bus.data_in = d;
      exp_q.push_back(d);
      @(negedge clock);
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int t;
      t = 0;
      while (res_q.size() < n && t < 3000) begin
         @(negedge clock);
         t++;
      end
      check("frames_arrived", (res_q.size() >= n) ? 1 : 0, 1);
   endtask

   task automatic check_frame(input string tag, input bit chk_gap);
      res_t r;
      if (res_q.size() == 0) begin
         check({tag, "_present"}, res_q.size(), 1);
         return;
      end
      r = res_q.pop_front();
      check({tag, "_wave"}, r.mism, 0);
      check({tag, "_busy"}, r.busy_n, FL);
      if (chk_gap) check({tag, "_gap"}, r.gap, 1);
   endtask

   // Line monitor: frames begin on the first low sample; a reset abandons the frame in progress.
   initial begin : monitor
      int         k;
      int         gap;
      int         mism;
      int         busy_n;
      logic       active;
      logic [3:0] nib;
      res_t       r;
      k = 0; gap = 0; mism = 0; busy_n = 0; active = 1'b0; nib = 4'd0;
      forever begin
         @(negedge clock);
         if (reset) begin
            active = 1'b0;
            gap    = 0;
         end else if (!active) begin
            if (bus.tx === 1'b0) begin
               active = 1'b1;
               k = 0; mism = 0; busy_n = 0;
               if (exp_q.size() > 0) begin
                  nib = exp_q.pop_front();
               end else begin
                  nib  = 4'd0;
                  mism = 1000;
               end
            end else begin
               gap++;
            end
         end
         if (active) begin
            if (bus.tx !== slot_bit(nib, k / C)) mism++;
            if (bus.busy === 1'b1) busy_n++;
            k++;
            if (k == FL) begin
               r.mism = mism; r.busy_n = busy_n; r.gap = gap;
               res_q.push_back(r);
               active = 1'b0;
               gap    = 0;
            end
         end
      end
   end

   initial begin : stim
      int   n;
      int   t;
      logic [3:0] v;
      bus.wr_en   = 1'b0;
      bus.data_in = 4'd0;
      reset       = 1'b1;
      repeat (3) @(negedge clock);

      // Reset state
      check("rst_tx", bus.tx, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_count", bus.count, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_ovf", bus.overflow, 0);
      reset = 1'b0;

      // Single frame 4'hA, first write right after reset release
      put(4'hA);
      check("first_write_count", bus.count, 1);
      wait_frames(1);
      check_frame("frame_A", 1'b0);
      @(negedge clock);
      check("after_A_tx", bus.tx, 1);
      check("after_A_busy", bus.busy, 0);
      check("after_A_empty", bus.empty, 1);

      // Two queued nibbles: exactly one idle cycle between frames
      put(4'h1);
      put(4'h2);
      wait_frames(2);
      check_frame("pair_1", 1'b0);
      check_frame("pair_2", 1'b1);

      // Random burst into an idle line
      n = $urandom_range(2, 8);
      for (int i = 0; i < n; i++) put(4'($urandom_range(0, 15)));
      wait_frames(n);
      for (int i = 0; i < n; i++) check_frame("burst", i > 0);

      // Fill while busy: 9 accepted, 10th dropped
      for (int i = 0; i < 9; i++) put(i[3:0]);
      check("fill_count", bus.count, 8);
      check("fill_full", bus.full, 1);
      check("fill_ovf", bus.overflow, 0);
      bus.wr_en   = 1'b1;
      bus.data_in = 4'h9;
      @(negedge clock);
      bus.wr_en   = 1'b0;
      check("drop_ovf", bus.overflow, 1);
      check("drop_count", bus.count, 8);
      wait_frames(9);
      for (int i = 0; i < 9; i++) check_frame("fill_seq", i > 0);
      check("fill_drained", bus.empty, 1);

      // Asynchronous reset in the middle of data bit 2
      put(4'h3);
      put(4'h5);
      repeat (3 * C + 1) @(negedge clock);
      check("bit2_tx_low", bus.tx, 0);
      check("bit2_count", bus.count, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_tx", bus.tx, 1);
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_count", bus.count, 0);
      check("async_rst_empty", bus.empty, 1);
      check("async_rst_ovf", bus.overflow, 0);
      @(negedge clock);
      exp_q.delete();
      res_q.delete();
      @(negedge clock);
      reset = 1'b0;
      put(4'h3);
      check("post_rst_count", bus.count, 1);
      wait_frames(1);
      check_frame("post_rst_3", 1'b0);

      // Full FIFO with a write on the pop edge
      for (int i = 0; i < 9; i++) put(4'($urandom_range(0, 15)));
      check("full2_full", bus.full, 1);
      t = 0;
      @(negedge clock);
      while (bus.busy !== 1'b0 && t < 200) begin
         @(negedge clock);
         t++;
      end
      check("idle_before_pop", bus.busy, 0);
      v = 4'($urandom_range(0, 15));
      put(v);
      check("pop_push_count", bus.count, 8);
      check("pop_push_ovf", bus.overflow, 0);
      check("pop_push_full", bus.full, 1);
      wait_frames(10);
      for (int i = 0; i < 10; i++) check_frame("pop_push_seq", i > 0);
      check("final_empty", bus.empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nibble_tx.md
NIBBLE_TX -- requirements
Module: nibble_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, 2..16.
REQ-003 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port wr_en, input, 1: processor OUT-strobe (control-word output-enable bit); when high, data_in is written this edge.
REQ-006 Port data_in, input, 4: nibble taken from the processor data bus.
REQ-007 Port tx, output, 1: serial line, idle high.
REQ-008 Port busy, output, 1: high while a frame is on the line (any state other than IDLE).
REQ-009 Port empty, output, 1: FIFO holds 0 entries.
REQ-010 Port full, output, 1: FIFO holds DEPTH entries.
REQ-011 Port count, output, 5: current FIFO occupancy, 0..DEPTH.
REQ-012 Port overflow, output, 1: sticky; set by a write dropped while full.

Function
REQ-013 FIFO: DEPTH x 4 bits; wrapping read/write pointers; first in, first out.
REQ-014 A write with wr_en=1 and full=0 stores data_in; count increments at the same edge.
REQ-015 A write with wr_en=1 and full=1 is dropped unless a pop occurs on the same edge; a dropped write sets overflow.
REQ-016 Simultaneous write and pop: both take effect; count unchanged; this includes the full case.
REQ-017 States: IDLE, START, DATA, PARITY (only when PARITY_EN is defined), STOP.
REQ-018 IDLE with empty=0: next edge pops the head entry into the shift register and enters START; tx=0 from that edge.
REQ-019 Each bit is held on tx for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads on each bit change.
REQ-020 DATA: 4 bits sent LSB first; a 2-bit index advances after each bit period; after bit 3, enter PARITY or STOP.
REQ-021 STOP: tx=1 for one bit period, then IDLE.
REQ-022 Back-to-back frames: if the FIFO is non-empty when STOP ends, the FSM still passes through IDLE for exactly one cycle (tx=1) before the next START.
REQ-023 Frame length without parity: 6*CLKS_PER_BIT cycles from START entry to IDLE entry, plus 1 IDLE cycle per frame.
REQ-024 tx, busy and the FSM state are registered outputs; no combinational path from wr_en to tx.
REQ-025 empty, full and count are derived from registered pointers and count only.

Reset
REQ-026 While reset=1, regardless of clock: state=IDLE, tx=1, busy=0, count=0, empty=1, full=0, overflow=0, pointers=0, bit counter=0.
REQ-027 Reset mid-frame aborts the frame immediately (tx=1) and discards all FIFO contents.
REQ-028 The first write is accepted at the first rising edge after reset deasserts.

Configuration
REQ-029 Macro NIBBLE_TX_PARITY_EN defined: after DATA, a PARITY state sends one even-parity bit (XOR of the 4 data bits) for CLKS_PER_BIT cycles; frame length becomes 7*CLKS_PER_BIT.
REQ-030 Macro NIBBLE_TX_PARITY_EN undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Verification
REQ-031 CLKS_PER_BIT=4, no parity; write 4'hA once -> starting the cycle after the pop edge, tx holds 0,0,1,0,1,1 for 4 cycles each; busy high for 24 cycles; then empty=1.
REQ-032 NIBBLE_TX_PARITY_EN defined, CLKS_PER_BIT=4; write 4'h7 -> tx holds 0,1,1,1,0,1(parity),1(stop) for 4 cycles each; frame is 28 cycles.
REQ-033 DEPTH=8, line busy; 9 consecutive writes 0..8 -> first nibble is popped one cycle after its write, so all 9 are accepted, full=1 and overflow=0; a 10th write while full with no pop -> dropped, overflow=1, count stays 8; nibbles later transmitted in order 0..8.
REQ-034 Full FIFO, write on the same edge the FSM pops -> count stays DEPTH, overflow stays 0, new nibble transmitted last.
REQ-035 Assert reset during DATA bit 2 -> tx=1, busy=0, count=0 without waiting for a clock edge; after release, write 4'h3 -> a clean full frame for 4'h3.
REQ-036 Two queued nibbles 4'h1, 4'h2 -> exactly one IDLE cycle with tx=1 between the STOP of the first frame and the START of the second.
